// File: rtl/wrr_pop_scheduler_pkg.sv
// Shared types and constants for the weighted round-robin VC pop scheduler.
package wrr_pop_scheduler_pkg;

    localparam int unsigned NumVc = 4;

    localparam logic [1:0] VCHANEL0 = 2'b00;
    localparam logic [1:0] VCHANEL1 = 2'b01;
    localparam logic [1:0] VCHANEL2 = 2'b10;
    localparam logic [1:0] VCHANEL3 = 2'b11;

    localparam logic [NumVc-1:0] EMPTY = 4'b0000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE  = 2'b01,
        RELOAD = 2'b10
    } state_e;

    function automatic logic [NumVc-1:0] vc_onehot(logic [1:0] idx);
        logic [NumVc-1:0] oh;
        oh = EMPTY;
        unique case (idx)
            VCHANEL0: oh = 4'b0001;
            VCHANEL1: oh = 4'b0010;
            VCHANEL2: oh = 4'b0100;
            VCHANEL3: oh = 4'b1000;
            default:  oh = EMPTY;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wrr_pop_scheduler_if.sv
// Handshake bundle between the VC FIFOs / output mux and the pop scheduler.
interface wrr_pop_scheduler_if;
    logic       enb;
    logic [3:0] vc_empty;
    logic       dst_ready;
    logic [3:0] pop;
    logic [1:0] arbiter;
    logic       valid_out;
    logic       round_done;

    modport master (
        output enb, vc_empty, dst_ready,
        input  pop, arbiter, valid_out, round_done
    );

    modport slave (
        input  enb, vc_empty, dst_ready,
        output pop, arbiter, valid_out, round_done
    );
endinterface

// File: rtl/wrr_pop_scheduler_rr_next_finder.sv
// Four-way circular priority search. With incl_start_i the order is start, start+1, ...;
// without it the start index is tried last (start+1, start+2, start+3, start).
module wrr_pop_scheduler_rr_next_finder
    import wrr_pop_scheduler_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    input  logic       incl_start_i,
    output logic [1:0] idx_o,
    output logic       found_o
);

    always_comb begin
        logic [1:0] cand;
        cand    = VCHANEL0;
        idx_o   = VCHANEL0;
        found_o = 1'b0;
        // Walk from the lowest priority up so the highest-priority hit wins last.
        for (int k = 3; k >= 0; k--) begin
            cand = start_i + 2'(k) + (incl_start_i ? 2'd0 : 2'd1);
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler for four VC FIFOs; emits pop strobes and an
// arbiter select registered to line up with the FIFOs' one-cycle read latency.
module wrr_pop_scheduler
    import wrr_pop_scheduler_pkg::*;
#(
    parameter int unsigned W0    = 4,
    parameter int unsigned W1    = 2,
    parameter int unsigned W2    = 1,
    parameter int unsigned W3    = 1,
    parameter int unsigned CNT_W = 4
) (
    input logic                clk,
    input logic                rst,
    wrr_pop_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] Wgt [NumVc] = '{CNT_W'(W0), CNT_W'(W1), CNT_W'(W2), CNT_W'(W3)};

    state_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       arbiter_q, arbiter_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] credit_q [NumVc];
    logic [CNT_W-1:0] credit_d [NumVc];

    logic [3:0] elig, elig_post, reload_mask, find_req;
    logic       find_incl, find_found, pop_en, last_credit;
    logic [1:0] find_idx;

    always_comb begin
        for (int i = 0; i < NumVc; i++) begin
            elig[i]        = !bus.vc_empty[i] && (credit_q[i] != '0);
            reload_mask[i] = !bus.vc_empty[i] && (Wgt[i] != '0);
        end
        pop_en      = (state_q == SERVE) && bus.enb && bus.dst_ready && elig[cur_q];
        last_credit = (credit_q[cur_q] == CNT_W'(1));
        // Search after a pop must see the decremented credit of cur.
        elig_post = elig;
        if (pop_en && last_credit) elig_post[cur_q] = 1'b0;

        find_incl = 1'b0;
        find_req  = reload_mask;
        if (state_q == IDLE) begin
            find_req  = elig;
            find_incl = 1'b1;
        end else if (state_q == SERVE) begin
            find_req = elig_post;
        end
    end

    wrr_pop_scheduler_rr_next_finder u_finder (
        .req_i        (find_req),
        .start_i      (cur_q),
        .incl_start_i (find_incl),
        .idx_o        (find_idx),
        .found_o      (find_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_q     <= VCHANEL0;
            arbiter_q <= VCHANEL0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NumVc; i++) credit_q[i] <= Wgt[i];
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            arbiter_q <= arbiter_d;
            valid_q   <= valid_d;
            credit_q  <= credit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        credit_d  = credit_q;
        arbiter_d = pop_en ? cur_q : arbiter_q;
        valid_d   = pop_en;
        if (pop_en) credit_d[cur_q] = credit_q[cur_q] - CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.enb) begin
                    if (|elig) begin
                        state_d = SERVE;
                        cur_d   = find_idx;
                    end else if (|reload_mask) begin
                        state_d = RELOAD;
                    end
                end
            end
            SERVE: begin
                // Advance on the last credit or when cur cannot be served (bubble).
                if (bus.enb && bus.dst_ready && !(pop_en && !last_credit)) begin
                    if (find_found) begin
                        cur_d = find_idx;
                    end else if (|reload_mask) begin
                        state_d = RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RELOAD: begin
                if (bus.enb) begin
                    credit_d = Wgt;
                    if (find_found) begin
                        state_d = SERVE;
                        cur_d   = find_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pop        = pop_en ? vc_onehot(cur_q) : EMPTY;
        bus.arbiter    = arbiter_q;
        bus.valid_out  = valid_q;
        bus.round_done = (state_q == RELOAD);
    end

endmodule

// File: doc/wrr_pop_scheduler.md
Name: wrr_pop_scheduler

Overview:
- Weighted round-robin scheduler that drives the pop and channel-select side of the four virtual-channel FIFOs feeding the `roundrobin` output mux.
- Decides which VC is popped each cycle from FIFO empty flags, per-channel weights and downstream readiness.
- Produces the registered `arbiter` select aligned with FIFO read data (1-cycle read latency), so `roundrobin` is driven by this block instead of a bench.

Parameters:
- W0, 4, credits (pops per round) for VC0; 0 disables the channel.
- W1, 2, credits for VC1.
- W2, 1, credits for VC2.
- W3, 1, credits for VC3.
- CNT_W, 4, credit counter width; every Wi must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-low.
- enb  in  1  block enable; low means no pops and all state held.
- vc_empty  in  4  per-VC FIFO empty flags, bit i = VC i.
- dst_ready  in  1  downstream can accept one word this cycle.
- pop  out  4  one-hot pop strobes to the VC FIFOs (combinational).
- arbiter  out  2  registered index of the VC popped in the previous cycle; drives `roundrobin.arbiter`.
- valid_out  out  1  registered; high when the FIFO data selected by `arbiter` is valid this cycle.
- round_done  out  1  high during the RELOAD cycle.

Behaviour:
- **Reset (rst=0, async):**
  - state=IDLE, cur=0, credit[i]=Wi.
  - pop=0, arbiter=0, valid_out=0, round_done=0.
- **Eligibility:** elig[i] = !vc_empty[i] && credit[i]!=0.
  - reloadable = OR over i of (!vc_empty[i] && Wi!=0).
- **Pop (combinational):** pop[cur] = (state==SERVE) && enb && dst_ready && elig[cur].
  - At most one pop bit is ever set.
  - A pop decrements credit[cur] by 1 at the next edge. Credit never underflows.
- **Output alignment:** at each edge, arbiter <= cur if |pop, else arbiter holds; valid_out <= |pop.
  - Latency: pop at cycle N → arbiter/valid_out valid at cycle N+1, matching the FIFO data.
- **Next-channel search:** first elig[j] in circular order cur+1, cur+2, cur+3, cur (wraps 3→0).
  - Uses post-decrement credits, so cur is skipped if its credit reaches 0.
- **IDLE:**
  - enb && any elig → SERVE, with cur = first eligible searching from cur inclusive.
  - enb && !any elig && reloadable → RELOAD.
  - Otherwise stay in IDLE.
- **SERVE** (when enb=0 or dst_ready=0: hold, no pop):
  - Pop with credit[cur]>1 → stay, same cur.
  - Pop with credit[cur]==1 → advance to the next eligible channel and stay in SERVE.
    - If none is eligible: RELOAD if reloadable, else IDLE.
  - !elig[cur] (FIFO emptied or credit 0) → advance per the same rule with no pop: one bubble cycle.
- **RELOAD:**
  - round_done=1, no pop, credit[i]<=Wi for all i.
  - Next state SERVE with cur = first j, searching from cur+1, having !vc_empty[j] && Wj!=0.
  - If that set is empty → IDLE.
  - enb=0 holds in RELOAD.
- **Boundary conditions:**
  - Weight-0 channels are never popped and never trigger a reload.
  - vc_empty rising in the same cycle as the last pop: pop is already gated by the current flag, so no pop of an empty FIFO.
  - Reset mid-operation: immediate return to the reset values; pending valid_out is dropped.
  - dst_ready low for any duration: no credit loss, cur unchanged.

Decomposition:
- Shared package (roundrobin package) holds:
  - channel constants VCHANEL0..VCHANEL3 (2'b00..2'b11);
  - state encoding IDLE=2'b00, SERVE=2'b01, RELOAD=2'b10;
  - EMPTY=4'b0000.
- One sub-module, rr_next_finder: combinational 4-way circular priority search (inputs: 4-bit request mask, 2-bit start index, include-start flag; outputs: 2-bit index, found).

Test Plan:
1. All vc_empty=0, dst_ready=1, enb=1, defaults.
   - pop sequence: 0,0,0,0,1,1,2,3, then one RELOAD cycle (round_done=1, pop=0), then repeat; period 9 cycles.
   - arbiter trails pop by exactly 1 cycle.
2. vc_empty=4'b1110 (only VC0 has data).
   - 4 pops of VC0, RELOAD, 4 pops, and so on; pop[3:1] never asserted.
3. VC1 holds 1 word (vc_empty[1] rises after its pop), others non-empty, starting at VC1.
   - 1 pop on VC1, one bubble cycle, then VC2 served.
   - No pop while vc_empty[1]=1.
4. dst_ready held 0 for 5 cycles mid-burst on VC0 with credit=2.
   - pop=0 and valid_out=0 for those cycles.
   - After release, exactly 2 more VC0 pops, then VC1.
5. All vc_empty=1.
   - Stays IDLE; pop=0, round_done=0.
   - Clearing vc_empty[2] gives pop[2] within 2 cycles.
6. rst asserted low mid-SERVE with credit[0]=1.
   - pop, arbiter and valid_out go to 0 asynchronously.
   - After release, VC0 again receives the full 4 pops.
